// File: rtl/mem_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_request_arbiter_if
//
// Bundles the CPU-side request buses (instruction fetch and data load/store)
// and the single-port RAM bus that mem_request_arbiter multiplexes between
// them.
//
//   slave  : the arbiter's view (takes CPU requests and RAM responses,
//            drives waits, load data and RAM strobes).
//   master : the environment's view (CPU requesters plus RAM), the mirror
//            image of slave.
//
// Signals
//   iREN, iaddr          instruction fetch request and address
//   iload, iwait         fetch data and fetch-not-complete flag
//   dREN, dWEN           data read / write request
//   daddr, dstore        data address and write data
//   dload, dwait         data read data and data-not-complete flag
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ram_ready   RAM read data and access-complete flag
// ---------------------------------------------------------------------------
interface mem_request_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// mem_request_arbiter
//
// Shares one single-port RAM between the CPU's instruction fetch and its data
// load/store path. A three-state FSM (IDLE, IACC, DACC) grants one requester
// at a time; the RAM address, write data and strobes are captured on the
// grant and held until the RAM signals ram_ready. In that completion cycle
// the granted requester's wait drops and its load bus carries ramload.
//
// Data requests win arbitration, but after MAX_DSTREAK consecutive data
// grants taken while a fetch was pending, the pending fetch is served next.
// MAX_DSTREAK = 0 gives strict data priority.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        asynchronous reset, active high
//   bus        mem_request_arbiter_if.slave (CPU request buses + RAM bus)
//   igrant_cnt completed fetch accesses        (ARB_STATS_EN only)
//   dgrant_cnt completed data accesses         (ARB_STATS_EN only)
//   stall_cnt  cycles with iwait or dwait high (ARB_STATS_EN only)
//
// Optional feature: define ARB_STATS_EN to add the three saturating CNT_W-bit
// statistics counters. Arbitration is identical with or without it.
// ---------------------------------------------------------------------------
module mem_request_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  mem_request_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      igrant_cnt,
  output logic [CNT_W-1:0]      dgrant_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  // The streak counter must be able to hold MAX_DSTREAK; keep at least one
  // bit so strict-priority builds still elaborate.
  localparam int unsigned           STREAK_W   = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mem_request_arbiter: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_e;

  state_e               state_q,     state_d;
  logic                 ram_ren_q,   ram_ren_d;
  logic                 ram_wen_q,   ram_wen_d;
  logic [31:0]          ram_addr_q,  ram_addr_d;
  logic [31:0]          ram_store_q, ram_store_d;
  logic [STREAK_W-1:0]  streak_q,    streak_d;

  logic data_req;
  logic fair_block;
  logic i_done;
  logic d_done;

  assign data_req = bus.dREN | bus.dWEN;

  // A pending fetch blocks the data path once the streak is exhausted.
  assign fair_block = (MAX_DSTREAK != 0) && bus.iREN && (streak_q == STREAK_MAX);

  assign i_done = (state_q == IACC) && bus.ram_ready;
  assign d_done = (state_q == DACC) && bus.ram_ready;

  // -------------------------------------------------------------------------
  // Next-state and register-capture logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold value before the case so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    streak_d    = streak_q;

    case (state_q)
      IDLE: begin
        if (data_req && !fair_block) begin
          state_d     = DACC;
          ram_addr_d  = bus.daddr;
          ram_store_d = bus.dstore;
          // A simultaneous read and write request is treated as a write.
          ram_wen_d   = bus.dWEN;
          ram_ren_d   = bus.dREN & ~bus.dWEN;
          if (!bus.iREN) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (bus.iREN) begin
          state_d    = IACC;
          ram_addr_d = bus.iaddr;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 1'b0;
          streak_d   = '0;
        end else begin
          streak_d = '0;
        end
      end

      IACC, DACC: begin
        // The access always runs to ram_ready, even if the requester has
        // let go of its request; the result is simply not waited for.
        if (bus.ram_ready) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the captured address and write data are reset too, because
      // they are visible on the RAM bus straight out of reset.
      state_q     <= IDLE;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      streak_q    <= streak_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ramREN   = ram_ren_q;
  assign bus.ramWEN   = ram_wen_q;
  assign bus.ramaddr  = ram_addr_q;
  assign bus.ramstore = ram_store_q;

  // Waits follow the request combinationally and drop only in the cycle the
  // requester's own access completes.
  assign bus.iwait = bus.iREN & ~i_done;
  assign bus.dwait = data_req & ~d_done;

  assign bus.iload = i_done ? bus.ramload : '0;
  assign bus.dload = d_done ? bus.ramload : '0;

`ifdef ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics counters, saturating at all-ones
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] igrant_cnt_q, igrant_cnt_d;
  logic [CNT_W-1:0] dgrant_cnt_q, dgrant_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

  always_comb begin
    igrant_cnt_d = igrant_cnt_q;
    dgrant_cnt_d = dgrant_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (i_done && (igrant_cnt_q != '1)) begin
      igrant_cnt_d = igrant_cnt_q + CNT_W'(1);
    end
    if (d_done && (dgrant_cnt_q != '1)) begin
      dgrant_cnt_d = dgrant_cnt_q + CNT_W'(1);
    end
    if ((bus.iwait || bus.dwait) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      igrant_cnt_q <= '0;
      dgrant_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      igrant_cnt_q <= igrant_cnt_d;
      dgrant_cnt_q <= dgrant_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign igrant_cnt = igrant_cnt_q;
  assign dgrant_cnt = dgrant_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_request_arbiter
//
// Drives mem_request_arbiter through directed scenarios (single fetch,
// simultaneous fetch/write, read+write collision, streak fairness, reset
// mid-access, statistics when ARB_STATS_EN is defined) and a long random
// phase. A transaction-level model tracks which requester owns the RAM, the
// last captured address/data and the data streak; every cycle the DUT
// outputs are compared against what that model says they must be.
// ---------------------------------------------------------------------------
module tb_mem_request_arbiter;

  localparam int unsigned MAX_DSTREAK = 4;
  localparam int unsigned CNT_W       = 32;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mem_request_arbiter_if bus ();

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] igrant_cnt;
  logic [CNT_W-1:0] dgrant_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

  mem_request_arbiter #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .igrant_cnt (igrant_cnt),
    .dgrant_cnt (dgrant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: who owns the RAM and with what transaction
  // -------------------------------------------------------------------------
  typedef enum {GR_NONE, GR_I, GR_D} owner_e;

  typedef struct {
    owner_e      who;
    logic [31:0] addr;
    logic        write;
  } txn_t;

  txn_t        m_cur;
  logic [31:0] m_last_addr;
  logic [31:0] m_last_store;
  int          m_streak;
  int unsigned m_icnt;
  int unsigned m_dcnt;
  int unsigned m_stall;
  logic        m_i_done;
  logic        m_d_done;

  byte dut_log[$];   // completion order as observed on the DUT waits

  task automatic model_reset();
    m_cur.who    = GR_NONE;
    m_cur.addr   = '0;
    m_cur.write  = 1'b0;
    m_last_addr  = '0;
    m_last_store = '0;
    m_streak     = 0;
    m_icnt       = 0;
    m_dcnt       = 0;
    m_stall      = 0;
    m_i_done     = 1'b0;
    m_d_done     = 1'b0;
  endtask

  function automatic logic want_data();
    return bus.dREN | bus.dWEN;
  endfunction

  function automatic logic exp_i_fin();
    return (m_cur.who == GR_I) && bus.ram_ready;
  endfunction

  function automatic logic exp_d_fin();
    return (m_cur.who == GR_D) && bus.ram_ready;
  endfunction

  // Called just after each rising edge, using the inputs of the cycle that
  // just ended.
  task automatic model_advance();
    if ((bus.iREN && !exp_i_fin()) || (want_data() && !exp_d_fin())) m_stall++;
    if (m_cur.who != GR_NONE) begin
      if (bus.ram_ready) begin
        if (m_cur.who == GR_I) m_icnt++;
        else                   m_dcnt++;
        m_cur.who = GR_NONE;
      end
    end else begin
      if (want_data() && !(bus.iREN && MAX_DSTREAK != 0 && m_streak >= int'(MAX_DSTREAK))) begin
        m_cur.who    = GR_D;
        m_cur.addr   = bus.daddr;
        m_cur.write  = bus.dWEN;
        m_last_addr  = bus.daddr;
        m_last_store = bus.dstore;
        m_streak     = bus.iREN ? ((m_streak + 1 > int'(MAX_DSTREAK)) ? int'(MAX_DSTREAK) : m_streak + 1) : 0;
      end else if (bus.iREN) begin
        m_cur.who   = GR_I;
        m_cur.addr  = bus.iaddr;
        m_cur.write = 1'b0;
        m_last_addr = bus.iaddr;
        m_streak    = 0;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    logic ifin;
    logic dfin;
    ifin = exp_i_fin();
    dfin = exp_d_fin();
    check("iwait",    32'(bus.iwait),  32'(bus.iREN && !ifin));
    check("dwait",    32'(bus.dwait),  32'(want_data() && !dfin));
    check("iload",    bus.iload,       ifin ? bus.ramload : 32'h0);
    check("dload",    bus.dload,       dfin ? bus.ramload : 32'h0);
    check("ramREN",   32'(bus.ramREN), 32'((m_cur.who == GR_I) || (m_cur.who == GR_D && !m_cur.write)));
    check("ramWEN",   32'(bus.ramWEN), 32'((m_cur.who == GR_D) && m_cur.write));
    check("ramaddr",  bus.ramaddr,     m_last_addr);
    check("ramstore", bus.ramstore,    m_last_store);
`ifdef ARB_STATS_EN
    check("igrant_cnt", igrant_cnt, m_icnt);
    check("dgrant_cnt", dgrant_cnt, m_dcnt);
    check("stall_cnt",  stall_cnt,  m_stall);
`endif
    m_i_done = bus.iREN && ifin;
    m_d_done = want_data() && dfin;
    if (bus.iREN && !bus.iwait)    dut_log.push_back("I");
    if (want_data() && !bus.dwait) dut_log.push_back("D");
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are
  // compared on the falling edge.
  task automatic sample();
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic advance();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  task automatic new_data_req(input logic en);
    int kind;
    if (en) begin
      kind       = int'($urandom_range(0, 2));
      bus.dREN   = (kind != 1);
      bus.dWEN   = (kind != 0);
      bus.daddr  = $urandom;
      bus.dstore = $urandom;
    end else begin
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    string exp_order;
    int    dn;
    logic  i_fin;
    logic  d_fin;

    RST           = 1'b1;
    bus.iREN      = 1'b0;
    bus.iaddr     = '0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.daddr     = '0;
    bus.dstore    = '0;
    bus.ramload   = '0;
    bus.ram_ready = 1'b0;
    model_reset();

    // Reset state
    sample();
    check("rst_ramREN",   32'(bus.ramREN), 0);
    check("rst_ramWEN",   32'(bus.ramWEN), 0);
    check("rst_ramaddr",  bus.ramaddr,     0);
    check("rst_ramstore", bus.ramstore,    0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // 1: single fetch, ready three cycles into the access
    bus.iREN    = 1'b1;
    bus.iaddr   = 32'h40;
    bus.ramload = 32'h8C01_0004;
    sample();
    check("t1_arb_iwait",  32'(bus.iwait),  1);
    check("t1_arb_ramREN", 32'(bus.ramREN), 0);
    advance();
    for (int k = 0; k < 3; k++) begin
      bus.ram_ready = (k == 2);
      sample();
      check("t1_ramREN",  32'(bus.ramREN), 1);
      check("t1_ramaddr", bus.ramaddr,     32'h40);
      check("t1_iwait",   32'(bus.iwait),  (k == 2) ? 0 : 1);
      check("t1_iload",   bus.iload,       (k == 2) ? 32'h8C01_0004 : 32'h0);
      advance();
    end
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    sample();
    check("t1_after_ramREN", 32'(bus.ramREN), 0);
    advance();

    // 2: fetch and write in the same cycle -> write first
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h200;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h100;
    bus.dstore = 32'hDEAD_BEEF;
    sample();
    advance();
    bus.ram_ready = 1'b1;
    sample();
    check("t2_ramWEN",   32'(bus.ramWEN), 1);
    check("t2_ramREN",   32'(bus.ramREN), 0);
    check("t2_ramstore", bus.ramstore,    32'hDEAD_BEEF);
    check("t2_ramaddr",  bus.ramaddr,     32'h100);
    check("t2_dwait",    32'(bus.dwait),  0);
    check("t2_iwait_d",  32'(bus.iwait),  1);
    advance();
    bus.dWEN = 1'b0;
    sample();
    check("t2_iwait_idle", 32'(bus.iwait), 1);
    advance();
    bus.ramload = 32'h1111_2222;
    sample();
    check("t2_iwait_done", 32'(bus.iwait), 0);
    check("t2_iload",      bus.iload,      32'h1111_2222);
    check("t2_iaddr",      bus.ramaddr,    32'h200);
    advance();
    bus.iREN      = 1'b0;
    bus.ram_ready = 1'b0;
    sample();
    advance();

    // 5: read and write together -> write
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h300;
    bus.dstore = 32'h1234_5678;
    sample();
    advance();
    bus.ram_ready = 1'b1;
    sample();
    check("t5_ramWEN", 32'(bus.ramWEN), 1);
    check("t5_ramREN", 32'(bus.ramREN), 0);
    advance();
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.ram_ready = 1'b0;
    sample();
    advance();

    // 3: streak fairness with a fetch held pending against data reads
    bus.ram_ready = 1'b1;
    bus.iREN      = 1'b1;
    bus.iaddr     = 32'h500;
    bus.dREN      = 1'b1;
    bus.dWEN      = 1'b0;
    bus.daddr     = 32'h1000;
    dut_log.delete();
    dn = 0;
    for (int c = 0; c < 80 && (bus.iREN || bus.dREN); c++) begin
      bus.ramload = $urandom;
      sample();
      i_fin = m_i_done;
      d_fin = m_d_done;
      advance();
      if (d_fin) begin
        dn++;
        if (dn < 8) bus.daddr = bus.daddr + 32'd4;
        else        bus.dREN  = 1'b0;
      end
      if (i_fin) begin
        if (dn < 8) bus.iaddr = bus.iaddr + 32'd4;
        else        bus.iREN  = 1'b0;
      end
    end
    check("t3_finished", {30'b0, bus.iREN, bus.dREN}, 0);
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    exp_order = "DDDDIDDDDI";
    check("t3_len", dut_log.size(), exp_order.len());
    for (int k = 0; k < exp_order.len() && k < dut_log.size(); k++) begin
      check($sformatf("t3_order[%0d]", k), 32'(dut_log[k]), 32'(exp_order[k]));
    end
    bus.ram_ready = 1'b0;
    sample();
    advance();

    // 4: reset in the middle of a data access
    bus.dREN  = 1'b1;
    bus.daddr = 32'h700;
    sample();
    advance();
    #1;
    RST = 1'b1;
    #1;
    check("t4_ramREN",  32'(bus.ramREN), 0);
    check("t4_ramWEN",  32'(bus.ramWEN), 0);
    check("t4_ramaddr", bus.ramaddr,     0);
    check("t4_dwait",   32'(bus.dwait),  1);
    model_reset();
    bus.ram_ready = 1'b1;
    #1;
    RST = 1'b0;
    sample();
    check("t4_late_ready_dwait", 32'(bus.dwait), 1);
    check("t4_late_ready_dload", bus.dload,      0);
    advance();
    sample();
    check("t4_regrant_dwait", 32'(bus.dwait), 0);
    advance();
    bus.dREN      = 1'b0;
    bus.ram_ready = 1'b0;
    sample();
    advance();

    // Random phase: requesters obey the hold-until-wait-drops contract
    for (int c = 0; c < 2000; c++) begin
      if (bus.iREN) begin
        if (m_i_done) begin
          bus.iREN  = 1'($urandom_range(0, 1));
          bus.iaddr = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.iREN  = 1'b1;
        bus.iaddr = $urandom;
      end
      if (want_data()) begin
        if (m_d_done) new_data_req(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 2) == 0) begin
        new_data_req(1'b1);
      end
      bus.ram_ready = ($urandom_range(0, 2) == 0);
      bus.ramload   = $urandom;
      sample();
      advance();
    end

`ifdef ARB_STATS_EN
    // 6: statistics over 3 fetches and 2 writes
    bus.iREN      = 1'b0;
    bus.dREN      = 1'b0;
    bus.dWEN      = 1'b0;
    bus.ram_ready = 1'b0;
    RST = 1'b1;
    #1;
    model_reset();
    RST = 1'b0;
    for (int op = 0; op < 5; op++) begin
      if (op % 2 == 0) begin
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h800 + 32'(op);
      end else begin
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h900 + 32'(op);
        bus.dstore = $urandom;
      end
      for (int k = 0; k < 3; k++) begin
        bus.ram_ready = (k == 2);
        sample();
        advance();
      end
      bus.iREN = 1'b0;
      bus.dWEN = 1'b0;
    end
    bus.ram_ready = 1'b0;
    sample();
    check("t6_igrant_cnt", igrant_cnt, 3);
    check("t6_dgrant_cnt", dgrant_cnt, 2);
    check("t6_stall_cnt",  stall_cnt,  10);
    advance();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
Shares the single-port RAM between instruction fetch and data access (load/store) in the CPU.
- A 3-state FSM grants one requester at a time and holds RAM strobes stable until the RAM reports ready.
- It returns load data and drops the requester's wait.
- Data requests have priority. A bounded-streak counter prevents instruction-fetch starvation.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while an instruction request is pending. 0 = strict data priority, no fairness.
- CNT_W, 32: width of statistics counters (used only with ARB_STATS_EN).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous reset, active-high.
- iREN  in  1  instruction fetch request.
- iaddr  in  32  fetch address.
- iload  out  32  fetch data.
- iwait  out  1  1 = fetch not complete.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  read data.
- dwait  out  1  1 = data access not complete.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  RAM access complete this cycle.

Behaviour:
- States: IDLE, IACC, DACC. Reset value: IDLE.
- Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, streak=0. iwait = iREN and dwait = (dREN|dWEN), combinationally.
- IDLE arbitration, evaluated each cycle:
  - dREN|dWEN and not (iREN and streak==MAX_DSTREAK and MAX_DSTREAK!=0) -> DACC.
  - else iREN -> IACC.
  - else stay in IDLE.
- On entering DACC, latch these registers, which are held constant for the whole access:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN. If dREN and dWEN are both high, the write wins.
- On entering IACC, latch ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore unchanged.
- Latency: request sampled in IDLE at cycle N; RAM strobes visible from cycle N+1.
- Completion:
  - In IACC/DACC with ram_ready=1, the active requester's wait drops combinationally in that cycle.
  - iload (or dload) = ramload in that cycle.
  - Next state is IDLE and the strobes clear.
  - Minimum access is 2 cycles (arbitrate + access).
- Wait outputs:
  - The non-granted requester's wait stays 1 while its request is high.
  - iwait=0 whenever iREN=0. dwait=0 whenever dREN|dWEN=0.
- Load outputs: iload/dload = ramload only during their completion cycle; 0 otherwise.
- Requester contract: hold the request and its address/data until its wait is 0; change or drop the request in the following cycle.
- Request dropped mid-access: the RAM access still runs to ram_ready and the result is discarded. No abort.
- Streak counter:
  - On a data grant with iREN=1: increment, saturating at MAX_DSTREAK.
  - On an instruction grant, or when iREN=0 in IDLE: clear.
- RST asserted mid-access: immediate return to IDLE, strobes low, counter 0. The RAM transaction is abandoned.
- ram_ready while in IDLE is ignored.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds outputs igrant_cnt, dgrant_cnt, stall_cnt (CNT_W each, reset 0, saturating at all-ones).
  - igrant_cnt / dgrant_cnt increment on each IACC / DACC completion.
  - stall_cnt increments on each cycle where iwait|dwait is 1.
- Undefined: ports and counters are absent. Arbitration behaviour is identical in both cases.

Test Plan:
1. iREN=1, iaddr=0x40, ram_ready high 3 cycles after strobe, ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 from cycle N+1; iwait=0 and iload=0x8C010004 only in the ready cycle; then IDLE.
2. iREN and dWEN asserted in the same cycle, daddr=0x100, dstore=0xDEADBEEF -> DACC first with ramWEN=1, ramREN=0, ramstore=0xDEADBEEF. iwait stays 1 until the following IACC completes.
3. MAX_DSTREAK=4, iREN held, 6 back-to-back data reads -> grant order D,D,D,D,I,D,...; streak returns to 0 after the I grant.
4. RST pulsed during DACC before ram_ready -> strobes 0 asynchronously, state IDLE, dwait=dREN. A ram_ready arriving afterward causes no completion.
5. dREN and dWEN both 1 -> ramWEN=1, ramREN=0.
6. With ARB_STATS_EN: 3 fetches + 2 writes, each taking 2 RAM-ready cycles -> igrant_cnt=3, dgrant_cnt=2; stall_cnt equals the count of wait-high cycles. Without the macro the design builds without these ports.
